// File: rtl/dm_bus_resp.sv
// rtl/dm_bus_resp.sv - multi-cycle data-memory responder with wait states and misalignment error
// Optional feature macro: DM_BYTE_LANE_EN (byte-lane masked writes; default build writes full words)
module dm_bus_resp #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

`ifdef DM_BYTE_LANE_EN
  // Lanes follow the latched enables exactly.
  localparam logic [3:0] LANE_FORCE = 4'b0000;
`else
  // Every aligned write replaces the whole word regardless of be.
  localparam logic [3:0] LANE_FORCE = 4'b1111;
`endif

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        we_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        access;
  logic        aligned;
  logic [7:0]  idx;
  logic [3:0]  lane_en;
  logic [31:0] wmask;

  assign access  = (state == S_WAIT) && (cnt == 4'd0);
  assign aligned = (addr_q[1:0] == 2'b00);
  assign idx     = addr_q[9:2];
  assign lane_en = be_q | LANE_FORCE;
  assign wmask   = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};

  // State register; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept only in IDLE, count down wait states, single response cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req) state_next = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state so ack drops the moment reset clears the state.
  always_comb begin
    busy = (state != S_IDLE);
    ack  = (state == S_RESP);
  end

  // Request latch, wait counter and registered response data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      if (state == S_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err   <= !aligned;
        rdata <= (aligned && !we_q) ? mem[idx] : 32'd0;
      end
    end
  end

  // Word array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (access && aligned && we_q) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wdata_q & wmask);
    end
  end

endmodule
